bnnseq_sample_scheduler: RTL and testbench
==========================================

# bnnseq_sample_scheduler

Sequencing controller for a bit-serial `bnnseq` classifier core (e.g. `cardio_bnn1_bnnseq`). It accepts feature vectors over a valid/ready stream and latches each one. It then drives the core's `rst`/`features` through one full evaluation of `FEAT_CNT+HIDDEN_CNT` cycles, captures `prediction`, and presents it on a one-entry valid/ready output slot. It replaces bench-driven reset/wait sequencing when the core is embedded in a streaming system.

## Interface
- `FEAT_CNT`, 19, features per sample
- `HIDDEN_CNT`, 40, hidden neurons in the core
- `FEAT_BITS`, 4, bits per feature
- `CLASS_CNT`, 3, output classes; class width `CW = $clog2(CLASS_CNT)`
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  sample offered
- `in_ready`  out  1  scheduler can accept a sample
- `in_features`  in  `FEAT_BITS*FEAT_CNT`  packed sample, same packing as the core
- `core_features`  out  `FEAT_BITS*FEAT_CNT`  latched sample to the core
- `core_rst`  out  1  core reset
- `core_prediction`  in  `CW`  core result
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `out_class`  out  `CW`  captured class
- `busy`  out  1  evaluation in progress, i.e. state is not IDLE

## Operation
- Constant `RUN_CYCLES = FEAT_CNT + HIDDEN_CNT`, which is 59 by default.
- Counter width is `$clog2(RUN_CYCLES)`.
- FSM states:
  - **IDLE**
    - `in_ready=1`.
    - On `in_valid`, latch `in_features` into the feature register and go to LOAD.
  - **LOAD**
    - `core_rst=1` for exactly one cycle.
    - Clear the counter and go to RUN.
  - **RUN**
    - `core_rst=0` and the counter increments each cycle.
    - When `cnt==RUN_CYCLES-1`, latch `core_prediction` into the result register.
    - Go to IDLE if the output slot is empty or drains this cycle (`out_valid&out_ready`), loading the slot.
    - Otherwise go to HOLD.
  - **HOLD**
    - Result is held internally.
    - When the slot is free (empty, or draining this cycle), load the slot and go to IDLE.
- `core_rst = rst | (state==LOAD)`.
- `core_features` is always driven from the feature register; it changes only on the accept edge.
- Output slot behaviour:
  - `out_valid` stays high until `out_ready` is sampled high.
  - `out_class` is stable while `out_valid`.
  - Simultaneous drain and load means a new result replaces the old one with no bubble.
- `in_ready` is low in LOAD, RUN and HOLD; the scheduler never accepts a second sample mid-evaluation.

## Timing
- Reset values:
  - state IDLE, `in_ready=1`, `out_valid=0`, `out_class=0`, `busy=0`, `core_rst=1`.
  - Counter 0; feature register 0.
- Latency with the slot free: the accept edge is edge 0, and `out_valid` rises after edge `RUN_CYCLES+1` (edge 60 by default).
- Throughput: a next accept is possible at the edge after the capture edge, giving one sample per `RUN_CYCLES+2` cycles (61).
- Stalled consumer:
  - The scheduler stays in HOLD indefinitely and `in_ready` stays low.
  - The capture in HOLD happens on the edge where `out_ready` is high.
- `rst` asserted mid-operation: every register takes its reset value next edge, the in-flight sample is discarded, and no output is produced.
- `in_valid` while not IDLE: ignored. The source must hold the sample per valid/ready rules.

## Configuration
- Macro `BNNSEQ_SCHED_CLAMP_EN`.
- Defined:
  - At capture, `core_prediction > CLASS_CNT-1` is replaced by `CLASS_CNT-1`.
  - An extra output `class_err` (1 bit) is set sticky on such an event and cleared only by `rst`.
- Undefined: `core_prediction` passes unmodified and the `class_err` port does not exist.

## Structure
- Shared package `bnnseq_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, HOLD);
  - a `RUN_CYCLES` helper function;
  - the `CW` width function.
- One sub-module `bnnseq_out_slot`: a single-entry valid/ready register with load/drain and simultaneous-replace.
- The FSM and counter stay in the top.

## Test plan
- Single sample, `out_ready=1`:
  - `core_rst` is high for exactly 1 cycle after accept.
  - `out_valid` rises after edge 60.
  - `out_class` equals the core prediction; repeated over 1000 samples, the results match the golden `cardio` predictions.
- Back-to-back stream, `in_valid` held high: accepts occur exactly 61 cycles apart and `in_ready` is low in between.
- `out_ready=0` for 100 cycles after the first result:
  - The second sample completes, and the state sits in HOLD with `busy=1` and `in_ready=0`.
  - Asserting `out_ready` drains result 1 and loads result 2 on the same edge.
- `rst` pulsed in RUN at `cnt=30`:
  - Next cycle shows `out_valid=0`, `in_ready=1`, `core_rst=1`.
  - No stale result ever appears.
- `in_valid` toggled during RUN with a different sample: `core_features` is unchanged and no extra accept occurs.
- `BNNSEQ_SCHED_CLAMP_EN` defined with a forced `core_prediction=3`:
  - `out_class=2` and `class_err=1`.
  - `class_err` persists until `rst`.

Source files
------------

// File: rtl/bnnseq_pkg.sv
// Shared types and sizing helpers for the bnnseq sample scheduler.
// Optional clamp feature: BNNSEQ_SCHED_CLAMP_EN (see bnnseq_sample_scheduler).
package bnnseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    function automatic int run_cycles(int feat_cnt, int hidden_cnt);
        return feat_cnt + hidden_cnt;
    endfunction

    function automatic int cw(int class_cnt);
        return (class_cnt > 1) ? $clog2(class_cnt) : 1;
    endfunction

endpackage

// File: rtl/bnnseq_out_slot.sv
// Single-entry valid/ready result register; a load on a draining edge
// replaces the old entry with no bubble.
module bnnseq_out_slot #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         free_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign free_o  = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = load_i | (valid_q & ~ready_i);
        data_d  = load_i ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/bnnseq_sample_scheduler.sv
// Drives one bit-serial bnnseq evaluation per accepted sample.
// Define BNNSEQ_SCHED_CLAMP_EN to clamp out-of-range classes and add class_err.
module bnnseq_sample_scheduler
    import bnnseq_pkg::*;
#(
    parameter int FEAT_CNT   = 19,
    parameter int HIDDEN_CNT = 40,
    parameter int FEAT_BITS  = 4,
    parameter int CLASS_CNT  = 3,
    localparam int CW        = cw(CLASS_CNT),
    localparam int FW        = FEAT_BITS * FEAT_CNT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] in_features,
    output logic [FW-1:0] core_features,
    output logic          core_rst,
    input  logic [CW-1:0] core_prediction,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_class,
`ifdef BNNSEQ_SCHED_CLAMP_EN
    output logic          class_err,
`endif
    output logic          busy
);

    localparam int RUN  = run_cycles(FEAT_CNT, HIDDEN_CNT);
    localparam int CNTW = $clog2(RUN);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [FW-1:0]   feat_q, feat_d;
    logic [CW-1:0]   res_q, res_d;
    logic [CW-1:0]   cap;
    logic [CW-1:0]   slot_data;
    logic            slot_load;
    logic            slot_free;
    logic            last;

    assign last = (cnt_q == CNTW'(RUN - 1));

`ifdef BNNSEQ_SCHED_CLAMP_EN
    logic over;
    logic err_q, err_d;

    assign over      = (core_prediction > CW'(CLASS_CNT - 1));
    assign cap       = over ? CW'(CLASS_CNT - 1) : core_prediction;
    assign err_d     = err_q | ((state_q == ST_RUN) & last & over);
    assign class_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign cap = core_prediction;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        feat_d    = feat_q;
        res_d     = res_q;
        slot_load = 1'b0;
        slot_data = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    feat_d  = in_features;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNTW'(1);
                if (last) begin
                    res_d = cap;
                    if (slot_free) begin
                        slot_load = 1'b1;
                        slot_data = cap;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    slot_load = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            feat_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            feat_q  <= feat_d;
            res_q   <= res_d;
        end
    end

    bnnseq_out_slot #(
        .W (CW)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (slot_load),
        .data_i  (slot_data),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_class),
        .free_o  (slot_free)
    );

    assign in_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign core_rst      = rst | (state_q == ST_LOAD);
    assign core_features = feat_q;

endmodule

// File: tb/tb_bnnseq_sample_scheduler.sv
// Directed bench for bnnseq_sample_scheduler with a behavioural core stand-in
// and a result scoreboard.
module tb_bnnseq_sample_scheduler;

    localparam int RUN = 59;
    localparam int FW  = 76;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_features;
    logic [FW-1:0] core_features;
    logic          core_rst;
    logic [1:0]    core_prediction;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_class;
    logic          busy;
`ifdef BNNSEQ_SCHED_CLAMP_EN
    logic          class_err;
`endif

    bnnseq_sample_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_features     (in_features),
        .core_features   (core_features),
        .core_rst        (core_rst),
        .core_prediction (core_prediction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_class       (out_class),
`ifdef BNNSEQ_SCHED_CLAMP_EN
        .class_err       (class_err),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] gold(logic [FW-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 19; i++) s += int'(v[i*4 +: 4]);
        return 2'(s % 3);
    endfunction

    function automatic logic [FW-1:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    // Core stand-in: the right class only on the final evaluation cycle.
    int   r;
    logic force3;
    always @(posedge clk) begin
        if (core_rst) r <= 0;
        else if (r < 1000) r <= r + 1;
    end
    always_comb begin
        if (force3) core_prediction = 2'd3;
        else if (r == RUN - 1) core_prediction = gold(core_features);
        else core_prediction = 2'((int'(gold(core_features)) + 1) % 3);
    end

    int         npass, ntotal;
    int         cyc, acc_cnt;
    logic       acc_seen;
    logic [1:0] exp_q[$];

    task automatic chk(string tag, int obs, int exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic          acc, drn;
        logic [1:0]    cls;
        logic [FW-1:0] fcap;
        acc  = in_valid && in_ready;
        drn  = out_valid && out_ready;
        cls  = out_class;
        fcap = in_features;
        @(posedge clk);
        #1;
        cyc++;
        acc_seen = acc;
        if (acc) begin
            acc_cnt++;
            exp_q.push_back(force3 ? 2'd2 : gold(fcap));
        end
        if (drn) begin
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else chk("out_class", int'(cls), int'(exp_q.pop_front()));
        end
    endtask

    task automatic send(logic [FW-1:0] f);
        int n;
        in_features = f;
        in_valid    = 1'b1;
        n = 0;
        tick();
        while (!acc_seen && n < 300) begin
            tick();
            n++;
        end
        if (!acc_seen) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [FW-1:0] fa, fb, fs;
        int            n, base, rdy_hi, bad, a0;
        int            acc_cyc[$];
        npass   = 0;
        ntotal  = 0;
        cyc     = 0;
        acc_cnt = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_features = '0;
        out_ready   = 1'b1;
        force3      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_core_rst", int'(core_rst), 1);
        chk("rst_features", int'(core_features == '0), 1);
        rst = 1'b0;
        #1;
        chk("idle_core_rst", int'(core_rst), 0);

        // single sample, latency and core_rst pulse
        fa = rnd();
        send(fa);
        in_features = rnd();
        chk("load_core_rst", int'(core_rst), 1);
        chk("load_features", int'(core_features == fa), 1);
        chk("load_in_ready", int'(in_ready), 0);
        tick();
        chk("run_core_rst", int'(core_rst), 0);
        n = 1;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("latency", n, RUN + 1);
        drain_all();

        // back-to-back stream
        base   = acc_cnt;
        rdy_hi = 0;
        n      = 0;
        in_features = rnd();
        in_valid    = 1'b1;
        while (acc_cnt < base + 3 && n < 400) begin
            if (acc_cnt > base && in_ready) rdy_hi++;
            tick();
            if (acc_seen) begin
                acc_cyc.push_back(cyc);
                in_features = rnd();
            end
            n++;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc_cnt - base, 3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], RUN + 2);
            chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], RUN + 2);
        end
        chk("b2b_ready_hi", rdy_hi, 2);
        drain_all();

        // stalled consumer
        out_ready = 1'b0;
        fa = rnd();
        fb = rnd();
        send(fa);
        send(fb);
        repeat (80) tick();
        chk("hold_out_valid", int'(out_valid), 1);
        chk("hold_busy", int'(busy), 1);
        chk("hold_in_ready", int'(in_ready), 0);
        chk("hold_class_a", int'(out_class), int'(gold(fa)));
        out_ready = 1'b1;
        tick();
        chk("replace_valid", int'(out_valid), 1);
        chk("replace_class_b", int'(out_class), int'(gold(fb)));
        chk("replace_busy", int'(busy), 0);
        tick();
        chk("replace_drained", int'(out_valid), 0);
        chk("stall_left", exp_q.size(), 0);

        // reset mid-run at cnt=30
        send(rnd());
        repeat (31) tick();
        rst = 1'b1;
        tick();
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_in_ready", int'(in_ready), 1);
        chk("mrst_core_rst", int'(core_rst), 1);
        chk("mrst_busy", int'(busy), 0);
        rst = 1'b0;
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid) bad++;
        end
        chk("mrst_stale", bad, 0);

        // in_valid toggling mid-evaluation
        fs = rnd();
        send(fs);
        a0  = acc_cnt;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid    = i[0];
            in_features = rnd();
            tick();
            if (core_features != fs) bad++;
        end
        in_valid = 1'b0;
        chk("toggle_features", bad, 0);
        chk("toggle_accepts", acc_cnt - a0, 0);
        drain_all();

`ifdef BNNSEQ_SCHED_CLAMP_EN
        chk("clamp_err_init", int'(class_err), 0);
        force3 = 1'b1;
        send(rnd());
        force3 = 1'b0;
        drain_all();
        chk("clamp_err_set", int'(class_err), 1);
        send(rnd());
        drain_all();
        chk("clamp_err_sticky", int'(class_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("clamp_err_clr", int'(class_err), 0);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
